fetch_dec_queue: RTL and testbench

FETCH_DEC_QUEUE -- requirements
Module: fetch_dec_queue

---
 rtl/fetch_dec_queue.sv | 84 ++++++++
 tb/tb_fetch_dec_queue.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fetch_dec_queue.sv
// Circular fetch-to-decode instruction queue with flush and async active-low reset.
// Optional combinational bypass when empty: define FETCH_DEC_QUEUE_BYPASS_EN.
module fetch_dec_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     fetch_valid,
    input  logic [31:0]              fetch_dec_instr,
    input  logic [31:0]              fetch_pc,
    output logic                     fetch_ready,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [31:0]              dec_instr,
    output logic [31:0]              dec_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          q_valid;
    logic          bypass;
    logic          push;
    logic          pop;

`ifdef FETCH_DEC_QUEUE_BYPASS_EN
    assign bypass = (count == '0) && fetch_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        q_valid     = (count != '0) && !flush;
        fetch_ready = (count < CW'(DEPTH)) && !flush;
        dec_valid   = q_valid || bypass;
        dec_instr   = NOP_INSTR;
        dec_pc      = '0;
        if (q_valid) begin
            dec_instr = mem_instr[rd_ptr];
            dec_pc    = mem_pc[rd_ptr];
        end else if (bypass) begin
            dec_instr = fetch_dec_instr;
            dec_pc    = fetch_pc;
        end
        // A bypassed entry consumed in the same cycle never touches storage.
        push = fetch_valid && fetch_ready && !(bypass && dec_ready);
        pop  = q_valid && dec_ready;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= fetch_dec_instr;
            mem_pc[wr_ptr]    <= fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_dec_queue.sv
// Directed scoreboard bench for fetch_dec_queue (DEPTH=4); expected entries queued on push,
// popped and compared as decode consumes them.
module tb_fetch_dec_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_dec_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [2:0]  count;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    logic [63:0] sb[$];

    fetch_dec_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .fetch_valid    (fetch_valid),
        .fetch_dec_instr(fetch_dec_instr),
        .fetch_pc       (fetch_pc),
        .fetch_ready    (fetch_ready),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the model at negedge, advance model at posedge.
    task automatic step(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                        input logic dr, input logic fl);
        logic        e_valid;
        logic        e_ready;
        logic        e_byp;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        fetch_valid     = fv;
        fetch_dec_instr = instr;
        fetch_pc        = pc;
        dec_ready       = dr;
        flush           = fl;
        @(negedge clk);
        e_byp = 1'b0;
`ifdef FETCH_DEC_QUEUE_BYPASS_EN
        e_byp = (sb.size() == 0) && fv && !fl;
`endif
        e_ready = (sb.size() < DEPTH) && !fl;
        e_valid = ((sb.size() != 0) && !fl) || e_byp;
        e_instr = NOP;
        e_pc    = '0;
        if ((sb.size() != 0) && !fl) begin
            e_instr = sb[0][63:32];
            e_pc    = sb[0][31:0];
        end else if (e_byp) begin
            e_instr = instr;
            e_pc    = pc;
        end
        chk("count",       64'(count),       64'(sb.size()));
        chk("fetch_ready", 64'(fetch_ready), 64'(e_ready));
        chk("dec_valid",   64'(dec_valid),   64'(e_valid));
        chk("dec_instr",   64'(dec_instr),   64'(e_instr));
        chk("dec_pc",      64'(dec_pc),      64'(e_pc));
        if (fl) begin
            sb.delete();
        end else begin
            if (e_valid && dr && !e_byp) void'(sb.pop_front());
            if (fv && e_ready && !(e_byp && dr)) sb.push_back({instr, pc});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
        fetch_dec_instr = '0; fetch_pc = '0;
        @(posedge clk); @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(dec_valid), 64'd0);
        chk("rst_instr", 64'(dec_instr), 64'(NOP));
        chk("rst_ready", 64'(fetch_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single push, visible the following cycle
        step(1'b1, 32'h0000_0093, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // five pushes into DEPTH=4, then full+pop cycle must not admit fetch
        for (int i = 0; i < 5; i++) step(1'b1, 32'hA000_0000 + 32'(i), 32'h100 + 32'(i * 4), 1'b0, 1'b0);
        step(1'b1, 32'hBAD0_0001, 32'h200, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // continuous streaming across pointer wrap
        for (int i = 0; i < 10; i++) step(1'b1, 32'hC000_0000 + 32'(i), 32'(i * 4), 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // flush with a concurrent fetch discards everything
        for (int i = 0; i < 3; i++) step(1'b1, 32'hD000_0000 + 32'(i), 32'h300 + 32'(i * 4), 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 32'h400, 1'b1, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'hE000_0000, 32'h500, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // asynchronous reset between edges
        step(1'b1, 32'hF000_0000, 32'h600, 1'b0, 1'b0);
        step(1'b1, 32'hF000_0001, 32'h604, 1'b0, 1'b0);
        fetch_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", 64'(count), 64'd0);
        chk("async_valid", 64'(dec_valid), 64'd0);
        chk("async_instr", 64'(dec_instr), 64'(NOP));
        chk("async_pc",    64'(dec_pc), 64'd0);
        chk("async_ready", 64'(fetch_ready), 64'd1);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b1, 32'h1111_1111, 32'h700, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // empty queue with fetch and decode both active
        step(1'b1, 32'h2222_2222, 32'h800, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
